// File: rtl/soc_pkg.sv
// Shared SoC bus-width constants used by the L2 bank interconnect.
package soc_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

endpackage

// File: rtl/l2_owner_fifo.sv
// Owner FIFO: remembers which master owns each in-flight L2 response, in grant order.
module l2_owner_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_en;
    logic          pop_en;

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            if (push_en && !pop_en)      count <= count + 1'b1;
            else if (pop_en && !push_en) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter letting NB_MASTERS TCDM masters share one L2 bank, with in-order response routing.
module l2_bank_rr_arbiter
    import soc_pkg::*;
#(
    parameter int unsigned NB_MASTERS  = 2,
    parameter int unsigned OWNER_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NB_MASTERS-1:0]        m_req_i,
    input  logic [NB_MASTERS*ADDR_W-1:0] m_add_i,
    input  logic [NB_MASTERS-1:0]        m_wen_i,
    input  logic [NB_MASTERS*BE_W-1:0]   m_be_i,
    input  logic [NB_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [NB_MASTERS-1:0]        m_gnt_o,
    output logic [NB_MASTERS-1:0]        m_r_valid_o,
    output logic [DATA_W-1:0]            m_r_rdata_o,
    output logic                         s_req_o,
    output logic [ADDR_W-1:0]            s_add_o,
    output logic                         s_wen_o,
    output logic [BE_W-1:0]              s_be_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    input  logic                         s_gnt_i,
    input  logic                         s_r_valid_i,
    input  logic [DATA_W-1:0]            s_r_rdata_i,
    output logic                         err_o
);

    localparam int unsigned IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;
    logic             any_req;
    logic             handshake;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [IDX_W-1:0] head;

    // Scan upward from rr_ptr, folding the index back into 0..NB_MASTERS-1
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NB_MASTERS; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NB_MASTERS) cand = cand - NB_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!any_req && m_req_i[cand_idx]) begin
                any_req = 1'b1;
                winner  = cand_idx;
            end
        end
    end

    assign s_req_o   = any_req && !fifo_full;
    assign handshake = s_req_o && s_gnt_i;
    assign pop       = s_r_valid_i && !fifo_empty;

    always_comb begin
        s_add_o   = '0;
        s_wen_o   = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (any_req) begin
            s_add_o   = m_add_i[winner*ADDR_W +: ADDR_W];
            s_wen_o   = m_wen_i[winner];
            s_be_o    = m_be_i[winner*BE_W +: BE_W];
            s_wdata_o = m_wdata_i[winner*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if (handshake) m_gnt_o[winner] = 1'b1;
        if (pop)       m_r_valid_o[head] = 1'b1;
    end

    assign m_r_rdata_o = s_r_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= (winner == IDX_W'(NB_MASTERS - 1)) ? '0 : winner + 1'b1;
            end
            if (s_r_valid_i && fifo_empty) err_o <= 1'b1;
        end
    end

    l2_owner_fifo #(
        .DEPTH (OWNER_DEPTH),
        .DW    (IDX_W)
    ) i_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (s_r_valid_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: doc/l2_bank_rr_arbiter.md
L2_BANK_RR_ARBITER -- requirements
Module: l2_bank_rr_arbiter

Interface
REQ-001 Parameter NB_MASTERS, default 2, is the number of TCDM masters sharing one L2 bank (2..8).
REQ-002 Parameter OWNER_DEPTH, default 2, is the number of in-flight responses tracked (power of 2, >=2).
REQ-003 clk_i  in  1  clock; all logic is on the rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 m_req_i  in  NB_MASTERS  per-master request.
REQ-006 m_add_i  in  NB_MASTERSx32  per-master byte address.
REQ-007 m_wen_i  in  NB_MASTERS  per-master write-enable, active-low (1 = read).
REQ-008 m_be_i  in  NB_MASTERSx4  per-master byte enables.
REQ-009 m_wdata_i  in  NB_MASTERSx32  per-master write data.
REQ-010 m_gnt_o  out  NB_MASTERS  per-master grant.
REQ-011 m_r_valid_o  out  NB_MASTERS  per-master response valid.
REQ-012 m_r_rdata_o  out  32  response data, broadcast to all masters.
REQ-013 s_req_o, s_add_o[32], s_wen_o, s_be_o[4], s_wdata_o[32]  out  request to the bank.
REQ-014 s_gnt_i, s_r_valid_i, s_r_rdata_i[32]  in  bank grant, response valid, response data.
REQ-015 err_o  out  1  sticky protocol-error flag.

Function
REQ-016 Winner = first index with m_req_i set, searching upward from rr_ptr and wrapping modulo NB_MASTERS.
REQ-017 s_req_o = (any m_req_i) AND NOT fifo_full; s_add_o/s_wen_o/s_be_o/s_wdata_o carry the winner's fields combinationally (zero when no request).
REQ-018 m_gnt_o[winner] = s_req_o AND s_gnt_i; all other m_gnt_o bits are 0; grant is in the same cycle as the request.
REQ-019 A handshake is s_req_o AND s_gnt_i; on a handshake rr_ptr <= (winner+1) mod NB_MASTERS, otherwise rr_ptr holds.
REQ-020 On every handshake the winner index is pushed into the owner FIFO (depth OWNER_DEPTH).
REQ-021 On s_r_valid_i the FIFO head is popped; m_r_valid_o[head] = s_r_valid_i; all other bits are 0; m_r_rdata_o = s_r_rdata_i unregistered.
REQ-022 Response to a write is still delivered as an m_r_valid_o pulse; ordering is strictly in grant order.
REQ-023 FIFO full: s_req_o held 0, no grant, rr_ptr holds; same-cycle pop and push when full is not possible because push is blocked (one-cycle bubble allowed).
REQ-024 Simultaneous push and pop when neither full nor empty: occupancy unchanged, both pointers advance.
REQ-025 s_r_valid_i with FIFO empty: no m_r_valid_o asserted, no pop, err_o set to 1 until reset.
REQ-026 Pointers wrap modulo OWNER_DEPTH; occupancy counter is $clog2(OWNER_DEPTH)+1 bits.
REQ-027 A single requesting master holding m_req_i is granted every cycle the bank grants (no forced idle).

Reset
REQ-028 While rst_ni=0: rr_ptr=0, FIFO pointers and count=0, err_o=0; hence m_r_valid_o=0 and, with no requests, s_req_o=0, m_gnt_o=0.
REQ-029 Reset mid-transaction discards all tracked owners; a late s_r_valid_i after reset sets err_o per REQ-025.

Structure
REQ-030 Bus widths (ADDR 32, DATA 32, BE 4) are constants in the shared SoC package soc_pkg; no new typedefs.
REQ-031 The owner FIFO is one sub-module, l2_owner_fifo, instantiated once; arbitration lives in the top module.

Verification
REQ-032 Masters 0 and 1 request every cycle, s_gnt_i=1, 1-cycle response -> grants alternate 0,1,0,1; each m_r_valid_o follows its grant by one cycle.
REQ-033 Master 1 writes 0xDEADBEEF to 0x1C010000 then master 0 reads it -> s_add_o/s_wdata_o match; master 0 receives 0xDEADBEEF one cycle after its grant.
REQ-034 s_gnt_i=1, s_r_valid_i held 0 for 3 cycles, OWNER_DEPTH=2 -> exactly two grants, then s_req_o=0 until first s_r_valid_i.
REQ-035 s_r_valid_i pulsed with no prior grant -> no m_r_valid_o bit set; err_o=1 and stays 1 until rst_ni low.
REQ-036 Assert rst_ni=0 with two responses outstanding -> all outputs at reset values next cycle; rr_ptr restarts so master 0 wins first.
REQ-037 NB_MASTERS=4, masters 1 and 3 requesting, rr_ptr=2 -> grant order 3,1,3,1.
